testport_checker: RTL

//  Parametrised self-check monitor for CPU/cache system benches. Watches the data-memory write bus for

---
 rtl/testport_checker.sv | 116 +++++++++++
 1 files changed

// File: rtl/testport_checker.sv
// testport_checker: test-port store monitor comparing stores against a loadable expected table (TESTPORT_TIMEOUT_EN adds a watchdog)
module testport_checker #(
    parameter int              AW        = 30,
    parameter logic [AW-1:0]   PORT_ADDR = 'h3FF,
    parameter logic [31:0]     BEGIN_SYM = 32'h00000168,
    parameter int              DEPTH     = 16,
    parameter int              EW        = 8,
    parameter int              DW        = 16,
    parameter int              SWAP      = 1,
    parameter logic [DW-1:0]   TO_CYC    = 16'hFFFF,
    localparam int             IW        = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   data,
    input  logic          wen,
    input  logic          cfg_we,
    input  logic [IW-1:0] cfg_idx,
    input  logic [31:0]   cfg_data,
    input  logic [IW:0]   cfg_num,
    output logic [EW-1:0] error_num,
    output logic [DW-1:0] duration,
    output logic [IW:0]   first_err,
    output logic          finish,
    output logic          timeout
);
    typedef enum logic [1:0] {IDLE, CHECK, REPORT} state_t;
    state_t        state, state_n;
    logic          wen_q, store, fin_n, to_n;
    logic [31:0]   d;
    logic [31:0]   tbl [DEPTH];
    logic [IW:0]   idx, idx_n, num, num_n, num_c, first_n;
    logic [EW-1:0] err_n;
    logic [DW-1:0] dur_n;
    assign store = wen && !wen_q && addr == PORT_ADDR;
    assign d     = SWAP != 0 ? {data[7:0], data[15:8], data[23:16], data[31:24]} : data;
    assign num_c = (cfg_num == '0 || cfg_num > (IW+1)'(DEPTH)) ? (IW+1)'(DEPTH) : cfg_num;
`ifdef TESTPORT_TIMEOUT_EN
    localparam int SW = (EW > IW + 1 ? EW : IW + 1) + 1;
    logic          last;
    logic [SW-1:0] sum;
    assign last = store && (idx + 1'b1 == num);
    assign sum  = SW'(error_num) + SW'(num - idx);
`endif
    // expected table: runtime loadable, never reset; compares read the pre-write value
    always_ff @(posedge clk) begin
        if (cfg_we) tbl[cfg_idx] <= cfg_data;
    end
    // next-state and next-output decision for the IDLE/CHECK/REPORT sequence
    always_comb begin
        state_n = state;
        err_n   = error_num;
        dur_n   = duration;
        idx_n   = idx;
        first_n = first_err;
        fin_n   = finish;
        to_n    = timeout;
        num_n   = num;
        if (state == IDLE) begin
            if (store && d == BEGIN_SYM) begin
                state_n = CHECK;
                err_n   = '0;
                dur_n   = '0;
                idx_n   = '0;
                num_n   = num_c;
            end
        end else if (state == CHECK) begin
            dur_n = &duration ? duration : duration + 1'b1;
            if (idx == num) begin
                state_n = REPORT;
                fin_n   = 1'b1;
            end
`ifdef TESTPORT_TIMEOUT_EN
            else if (duration == TO_CYC - 1'b1 && !last) begin
                state_n = REPORT;
                fin_n   = 1'b1;
                to_n    = 1'b1;
                dur_n   = duration;
                err_n   = |(sum >> EW) ? '1 : sum[EW-1:0];
            end
`endif
            else if (store) begin
                idx_n = idx + 1'b1;
                if (d != tbl[idx[IW-1:0]]) begin
                    err_n   = &error_num ? error_num : error_num + 1'b1;
                    first_n = &first_err ? idx : first_err;
                end
            end
        end
    end
    // state and output registers; reset overrides every other event
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            error_num <= '1;
            duration  <= '0;
            idx       <= '0;
            num       <= '0;
            first_err <= '1;
            finish    <= 1'b0;
            timeout   <= 1'b0;
            wen_q     <= 1'b0;
        end else begin
            state     <= state_n;
            error_num <= err_n;
            duration  <= dur_n;
            idx       <= idx_n;
            num       <= num_n;
            first_err <= first_n;
            finish    <= fin_n;
            timeout   <= to_n;
            wen_q     <= wen;
        end
    end
endmodule
